// File: rtl/rv_isa_pkg.sv
// Shared RV64I encoding constants, loader format codes and FSM state type.
package rv_isa_pkg;

    localparam int unsigned INSN_W = 32;
    localparam int unsigned FMT_W  = 3;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned F3_W   = 3;
    localparam int unsigned IMM_W  = 12;
    localparam int unsigned OPC_W  = 7;

    localparam logic [OPC_W-1:0] OP_IMM    = 7'b0010011;
    localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;

    localparam logic [FMT_W-1:0] FMT_RAW    = 3'd0;
    localparam logic [FMT_W-1:0] FMT_OPIMM  = 3'd1;
    localparam logic [FMT_W-1:0] FMT_LOAD   = 3'd2;
    localparam logic [FMT_W-1:0] FMT_STORE  = 3'd3;
    localparam logic [FMT_W-1:0] FMT_BRANCH = 3'd4;

    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [F3_W-1:0]  funct3;
        logic [IMM_W-1:0] imm;
    } insn_fields_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_e;

endpackage

// File: rtl/insn_encoder.sv
// Combinational field-to-instruction encoder; unknown formats flag fmt_bad_c and yield zero.
module insn_encoder
    import rv_isa_pkg::*;
(
    input  logic [FMT_W-1:0]  fmt,
    input  logic [INSN_W-1:0] raw,
    input  insn_fields_t      fields,
    output logic [INSN_W-1:0] word_c,
    output logic              fmt_bad_c
);

    always_comb begin
        word_c    = '0;
        fmt_bad_c = 1'b0;
        case (fmt)
            FMT_RAW:    word_c = raw;
            FMT_OPIMM:  word_c = {fields.imm, fields.rs1, fields.funct3, fields.rd, OP_IMM};
            FMT_LOAD:   word_c = {fields.imm, fields.rs1, fields.funct3, fields.rd, OP_LOAD};
            FMT_STORE:  word_c = {fields.imm[11:5], fields.rs2, fields.rs1, fields.funct3,
                                  fields.imm[4:0], OP_STORE};
            // B-type scatters the half-word offset around the register fields
            FMT_BRANCH: word_c = {fields.imm[11], fields.imm[9:4], fields.rs2, fields.rs1,
                                  fields.funct3, fields.imm[3:0], fields.imm[10], OP_BRANCH};
            default:    fmt_bad_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/imem_loader.sv
// Streams encoded 32-bit instruction words into a byte-wide little-endian imem, one byte per cycle.
module imem_loader
    import rv_isa_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [31:0]       in_raw,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [11:0]       in_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              full,
    output logic [ADDR_W-2:0] word_count,
    output logic [31:0]       last_word,
    output logic              err_overflow,
    output logic              err_fmt
);

    localparam int unsigned CNT_W = ADDR_W - 1;
    localparam logic [ADDR_W-1:0] BASE_PTR = ADDR_W'(BASE_ADDR) & ~ADDR_W'(3);

    insn_fields_t      fields;
    logic [INSN_W-1:0] enc_word_c;
    logic              fmt_bad_c;

    assign fields = '{rd: in_rd, rs1: in_rs1, rs2: in_rs2, funct3: in_funct3, imm: in_imm};

    insn_encoder u_enc (
        .fmt       (in_fmt),
        .raw       (in_raw),
        .fields    (fields),
        .word_c    (enc_word_c),
        .fmt_bad_c (fmt_bad_c)
    );

    state_e            state, state_n;
    logic [1:0]        byte_ctr, byte_ctr_n;
    logic [INSN_W-1:0] shreg, shreg_n;
    logic [ADDR_W-1:0] ptr, ptr_n;
    logic              clr_pend, clr_pend_n;
    logic [CNT_W-1:0]  word_count_n;
    logic [31:0]       last_word_n;
    logic              full_n, err_overflow_n, err_fmt_n;
    logic              mem_we_n, in_ready_n, busy_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [7:0]        mem_wdata_n;

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            byte_ctr     <= '0;
            shreg        <= '0;
            ptr          <= BASE_PTR;
            clr_pend     <= 1'b0;
            word_count   <= '0;
            last_word    <= '0;
            full         <= 1'b0;
            err_overflow <= 1'b0;
            err_fmt      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            in_ready     <= 1'b1;
            busy         <= 1'b0;
        end else begin
            state        <= state_n;
            byte_ctr     <= byte_ctr_n;
            shreg        <= shreg_n;
            ptr          <= ptr_n;
            clr_pend     <= clr_pend_n;
            word_count   <= word_count_n;
            last_word    <= last_word_n;
            full         <= full_n;
            err_overflow <= err_overflow_n;
            err_fmt      <= err_fmt_n;
            mem_we       <= mem_we_n;
            mem_addr     <= mem_addr_n;
            mem_wdata    <= mem_wdata_n;
            in_ready     <= in_ready_n;
            busy         <= busy_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n        = state;
        byte_ctr_n     = byte_ctr;
        shreg_n        = shreg;
        ptr_n          = ptr;
        clr_pend_n     = clr_pend;
        word_count_n   = word_count;
        last_word_n    = last_word;
        full_n         = full;
        err_overflow_n = err_overflow;
        err_fmt_n      = err_fmt;
        mem_we_n       = 1'b0;
        mem_addr_n     = mem_addr;
        mem_wdata_n    = mem_wdata;

        case (state)
            ST_IDLE: begin
                if (clear) begin
                    ptr_n          = BASE_PTR;
                    word_count_n   = '0;
                    full_n         = 1'b0;
                    err_overflow_n = 1'b0;
                    err_fmt_n      = 1'b0;
                    clr_pend_n     = 1'b0;
                end else if (in_valid && full) begin
                    err_overflow_n = 1'b1;
                end else if (in_valid && in_ready) begin
                    if (fmt_bad_c) begin
                        err_fmt_n = 1'b1;
                    end else begin
                        last_word_n = enc_word_c;
                        shreg_n     = enc_word_c >> 8;
                        mem_we_n    = 1'b1;
                        mem_addr_n  = ptr;
                        mem_wdata_n = enc_word_c[7:0];
                        byte_ctr_n  = 2'd1;
                        state_n     = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (clear) begin
                    clr_pend_n = 1'b1;
                end
                if (byte_ctr != 2'd0) begin
                    mem_we_n    = 1'b1;
                    mem_addr_n  = {ptr[ADDR_W-1:2], byte_ctr};
                    mem_wdata_n = shreg[7:0];
                    shreg_n     = shreg >> 8;
                    byte_ctr_n  = 2'(byte_ctr + 2'd1);
                end else begin
                    // A clear raised during the word discards this word's bookkeeping
                    state_n = ST_IDLE;
                    if (clear || clr_pend) begin
                        ptr_n          = BASE_PTR;
                        word_count_n   = '0;
                        full_n         = 1'b0;
                        err_overflow_n = 1'b0;
                        err_fmt_n      = 1'b0;
                        clr_pend_n     = 1'b0;
                    end else begin
                        ptr_n        = ADDR_W'(ptr + ADDR_W'(4));
                        word_count_n = CNT_W'(word_count + CNT_W'(1));
                        full_n       = (ptr_n == '0);
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase

        busy_n     = (state_n == ST_WRITE);
        in_ready_n = (state_n == ST_IDLE) && !full_n && !clr_pend_n;
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: encoding table, byte streaming, clear/reset/full corner cases.
module tb_imem_loader;

    logic        clk, rst_n, clear, in_valid, in_ready;
    logic [2:0]  in_fmt;
    logic [31:0] in_raw;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [11:0] in_imm;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        busy, full;
    logic [6:0]  word_count;
    logic [31:0] last_word;
    logic        err_overflow, err_fmt;

    imem_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_raw(in_raw), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_imm(in_imm), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .full(full), .word_count(word_count),
        .last_word(last_word), .err_overflow(err_overflow), .err_fmt(err_fmt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  fmt;
        logic [31:0] raw;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [11:0] imm;
        logic [31:0] exp_word;
    } vec_t;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;
    logic [7:0]  exp_ptr = 8'd0;
    int unsigned exp_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic drive(input vec_t v);
        in_fmt = v.fmt; in_raw = v.raw; in_rd = v.rd; in_rs1 = v.rs1;
        in_rs2 = v.rs2; in_funct3 = v.f3; in_imm = v.imm;
    endtask

    // Called on a negedge; returns on the negedge of cycle T+5
    task automatic send(input vec_t v);
        int unsigned w;
        logic [31:0] wd;
        logic        exp_full;
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("in_ready_before", in_ready, 1);
        drive(v);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wd = v.exp_word;
        for (int k = 0; k < 4; k++) begin
            chk("mem_we", mem_we, 1);
            chk("mem_addr", mem_addr, 32'(8'(exp_ptr + 8'(k))));
            chk("mem_wdata", mem_wdata, 32'(wd[8*k +: 8]));
            @(negedge clk);
        end
        exp_ptr  = 8'(exp_ptr + 8'd4);
        exp_cnt  = exp_cnt + 1;
        exp_full = (exp_ptr == 8'd0);
        chk("mem_we_after", mem_we, 0);
        chk("last_word", last_word, wd);
        chk("word_count", 32'(word_count), exp_cnt);
        chk("full", full, 32'(exp_full));
        chk("in_ready_after", in_ready, 32'(!exp_full));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_ptr = 8'd0;
        exp_cnt = 0;
        @(negedge clk);
    endtask

    vec_t tbl [5];
    vec_t v;

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0;
        in_fmt = '0; in_raw = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_funct3 = '0; in_imm = '0;

        tbl[0] = '{3'd1, 32'h0,        5'd1, 5'd0, 5'd0, 3'd0, 12'd5,   32'h00500093};
        tbl[1] = '{3'd2, 32'h0,        5'd3, 5'd1, 5'd0, 3'd3, 12'd16,  32'h0100B183};
        tbl[2] = '{3'd3, 32'h0,        5'd0, 5'd1, 5'd2, 3'd3, 12'd8,   32'h0020B423};
        tbl[3] = '{3'd4, 32'h0,        5'd0, 5'd1, 5'd2, 3'd0, 12'h004, 32'h00208463};
        tbl[4] = '{3'd0, 32'hDEADBEEF, 5'd0, 5'd0, 5'd0, 3'd0, 12'd0,   32'hDEADBEEF};

        do_reset();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_full", full, 0);
        chk("rst_count", 32'(word_count), 0);
        chk("rst_last_word", last_word, 0);
        chk("rst_errs", {err_overflow, err_fmt}, 0);

        for (int i = 0; i < 5; i++) send(tbl[i]);

        // Unsupported format: accepted, flagged, nothing written
        v = tbl[0]; v.fmt = 3'd6;
        drive(v); in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("badfmt_err", err_fmt, 1);
        chk("badfmt_we", mem_we, 0);
        chk("badfmt_count", 32'(word_count), 5);
        chk("badfmt_ready", in_ready, 1);

        // clear and in_valid together: clear wins
        drive(tbl[4]); clear = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0;
        chk("clrv_we", mem_we, 0);
        chk("clrv_busy", busy, 0);
        chk("clrv_count", 32'(word_count), 0);
        chk("clrv_err_fmt", err_fmt, 0);
        chk("clrv_ready", in_ready, 1);
        exp_ptr = 8'd0; exp_cnt = 0;

        // Two words, then clear during byte 1 of the third
        send(tbl[1]);
        send(tbl[2]);
        drive(tbl[4]); in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("clrw_b0_addr", mem_addr, 8);
        @(negedge clk);
        chk("clrw_b1_we", mem_we, 1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clrw_b2_we", mem_we, 1);
        chk("clrw_b2_data", mem_wdata, 8'hAD);
        chk("clrw_b2_ready", in_ready, 0);
        @(negedge clk);
        chk("clrw_b3_we", mem_we, 1);
        chk("clrw_b3_addr", mem_addr, 11);
        chk("clrw_b3_data", mem_wdata, 8'hDE);
        @(negedge clk);
        chk("clrw_done_we", mem_we, 0);
        chk("clrw_done_count", 32'(word_count), 0);
        chk("clrw_done_ready", in_ready, 1);
        exp_ptr = 8'd0; exp_cnt = 0;
        send(tbl[3]);

        // Reset during byte 2
        drive(tbl[0]); in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rstw_b2_we", mem_we, 1);
        rst_n = 1'b0;
        #1;
        chk("rstw_we_drop", mem_we, 0);
        chk("rstw_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_ptr = 8'd0; exp_cnt = 0;
        @(negedge clk);
        chk("rstw_ready", in_ready, 1);
        chk("rstw_count", 32'(word_count), 0);
        chk("rstw_we_idle", mem_we, 0);

        // Fill all 64 words
        for (int i = 0; i < 64; i++) begin
            v = tbl[4];
            v.raw = {4{8'(i + 8'h10)}};
            v.exp_word = v.raw;
            send(v);
        end
        chk("fill_full", full, 1);
        chk("fill_ready", in_ready, 0);
        chk("fill_count", 32'(word_count), 64);

        // Request while full
        drive(tbl[4]); in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ovf_no_we", mem_we, 0);
        end
        in_valid = 1'b0;
        chk("ovf_err", err_overflow, 1);
        chk("ovf_busy", busy, 0);

        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("postclr_full", full, 0);
        chk("postclr_ovf", err_overflow, 0);
        chk("postclr_ready", in_ready, 1);
        exp_ptr = 8'd0; exp_cnt = 0;
        send(tbl[0]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
